// File: rtl/stepper_move_ctrl.sv
// Single-axis stepper move controller: drives a 4-coil phase pattern for a
// commanded number of steps with a linear start ramp and boundary abort.
module stepper_move_ctrl #(
  parameter int STEP_W = 12,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              dir,
  input  logic              half_step,
  input  logic [STEP_W-1:0] steps,
  input  logic [DIV_W-1:0]  period,
  input  logic [DIV_W-1:0]  start_period,
  input  logic [DIV_W-1:0]  ramp_dec,
  input  logic [3:0]        old_phase,
  input  logic              boundary,
  output logic [3:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic              dir_q, dir_d;
  logic              half_q, half_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] steps_done_q, steps_done_d;
  logic [DIV_W-1:0]  period_eff_q, period_eff_d;
  logic [DIV_W-1:0]  ramp_q, ramp_d;
  logic [DIV_W-1:0]  cur_period_q, cur_period_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              aborted_q, aborted_d;

  logic [DIV_W-1:0]  period_eff_in;
  logic [DIV_W-1:0]  start_eff;
  logic [DIV_W-1:0]  dec_sat;
  logic [DIV_W-1:0]  ramped;
  logic [STEP_W-1:0] steps_done_inc;
  logic              tick;

  function automatic logic [3:0] idx_to_phase(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // Unknown coil patterns resume from the two-coil entry 1100.
  function automatic logic [2:0] phase_to_idx(input logic [3:0] p);
    logic [2:0] i;
    case (p)
      4'b1000: i = 3'd0;
      4'b1100: i = 3'd1;
      4'b0100: i = 3'd2;
      4'b0110: i = 3'd3;
      4'b0010: i = 3'd4;
      4'b0011: i = 3'd5;
      4'b0001: i = 3'd6;
      4'b1001: i = 3'd7;
      default: i = 3'd1;
    endcase
    return i;
  endfunction

  // Full-step from an even (single-coil) index moves by one to re-align onto
  // the two-coil entries; the 3-bit index wraps mod 8 naturally.
  function automatic logic [2:0] next_idx(input logic [2:0] i, input logic fwd,
                                          input logic half);
    logic [2:0] delta;
    delta = (half || !i[0]) ? 3'd1 : 3'd2;
    return fwd ? i + delta : i - delta;
  endfunction

  always_comb begin
    period_eff_in  = (period == '0) ? DIV_W'(1) : period;
    start_eff      = (start_period > period_eff_in) ? start_period : period_eff_in;
    dec_sat        = (cur_period_q > ramp_q) ? (cur_period_q - ramp_q) : '0;
    ramped         = (dec_sat > period_eff_q) ? dec_sat : period_eff_q;
    steps_done_inc = steps_done_q + STEP_W'(1);
    tick           = (cnt_q == cur_period_q - DIV_W'(1));
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    half_d       = half_q;
    steps_d      = steps_q;
    steps_done_d = steps_done_q;
    period_eff_d = period_eff_q;
    ramp_d       = ramp_q;
    cur_period_d = cur_period_q;
    cnt_d        = cnt_q;
    aborted_d    = aborted_q;

    case (state_q)
      IDLE: begin
        idx_d     = phase_to_idx(old_phase);
        aborted_d = 1'b0;
        if (go) begin
          dir_d        = dir;
          half_d       = half_step;
          steps_d      = steps;
          period_eff_d = period_eff_in;
          ramp_d       = ramp_dec;
          cur_period_d = start_eff;
          steps_done_d = '0;
          cnt_d        = '0;
          if (boundary) begin
            state_d   = DONE;
            aborted_d = 1'b1;
          end else if (steps == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Release and boundary both pre-empt a coincident step.
        if (!go) begin
          state_d = IDLE;
        end else if (boundary) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (tick) begin
          idx_d        = next_idx(idx_q, dir_q, half_q);
          steps_done_d = steps_done_inc;
          cnt_d        = '0;
          cur_period_d = ramped;
          if (steps_done_inc == steps_q) state_d = DONE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        if (!go) begin
          state_d   = IDLE;
          aborted_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 3'd1;
      dir_q        <= 1'b0;
      half_q       <= 1'b0;
      steps_q      <= '0;
      steps_done_q <= '0;
      period_eff_q <= '0;
      ramp_q       <= '0;
      cur_period_q <= '0;
      cnt_q        <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      half_q       <= half_d;
      steps_q      <= steps_d;
      steps_done_q <= steps_done_d;
      period_eff_q <= period_eff_d;
      ramp_q       <= ramp_d;
      cur_period_q <= cur_period_d;
      cnt_q        <= cnt_d;
      aborted_q    <= aborted_d;
    end
  end

  assign phase      = idx_to_phase(idx_q);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign aborted    = aborted_q;
  assign steps_done = steps_done_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl: directed test-plan moves plus
// randomized moves, checked cycle by cycle against an arithmetic move model.
module tb_stepper_move_ctrl;

  localparam int STEP_W = 12;
  localparam int DIV_W  = 24;
  localparam int NEVER  = 1 << 30;
  localparam logic [3:0] PTAB [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                      4'b0010, 4'b0011, 4'b0001, 4'b1001};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0;
  logic              dir = 1'b0;
  logic              half_step = 1'b0;
  logic [STEP_W-1:0] steps = '0;
  logic [DIV_W-1:0]  period = '0;
  logic [DIV_W-1:0]  start_period = '0;
  logic [DIV_W-1:0]  ramp_dec = '0;
  logic [3:0]        old_phase = 4'b0000;
  logic              boundary = 1'b0;
  logic [3:0]        phase;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_done;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stepper_move_ctrl #(.STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .dir(dir), .half_step(half_step),
    .steps(steps), .period(period), .start_period(start_period),
    .ramp_dec(ramp_dec), .old_phase(old_phase), .boundary(boundary),
    .phase(phase), .busy(busy), .done(done), .aborted(aborted),
    .steps_done(steps_done)
  );

  function automatic int map_idx(input logic [3:0] p);
    for (int i = 0; i < 8; i++) if (PTAB[i] == p) return i;
    return 1;
  endfunction

  // Edge 0 is the edge that samples go; b/d are the edges at which boundary
  // is first seen high / go is first seen low (NEVER if they do not happen).
  task automatic run_move(input string name, input logic dir_v, input logic half_v,
                          input int steps_v, input int period_v, input int start_v,
                          input int ramp_v, input logic [3:0] old_v,
                          input int b, input int d);
    int t_step [0:63];
    int pe, cur, t, tfin, endrun, stop, kmax, n, idx, idx0;
    logic abortflag;
    logic [3:0] e_ph;
    logic e_busy, e_done, e_ab;
    pe = (period_v == 0) ? 1 : period_v;
    cur = (start_v > pe) ? start_v : pe;
    t = 0;
    for (int i = 1; i <= steps_v; i++) begin
      t += cur;
      t_step[i] = t;
      cur = (cur > ramp_v) ? cur - ramp_v : 0;
      if (cur < pe) cur = pe;
    end
    tfin = (steps_v > 0) ? t_step[steps_v] : 0;
    stop = (b < d) ? b : d;
    if (steps_v == 0 || b == 0) endrun = 0;
    else endrun = (tfin < stop) ? tfin : stop;
    abortflag = (b < d) && (b == 0 || (steps_v > 0 && b <= tfin));
    kmax = ((d != NEVER && d > endrun) ? d : endrun) + 3;
    idx0 = map_idx(old_v);

    @(negedge clk);
    dir = dir_v; half_step = half_v; steps = STEP_W'(steps_v);
    period = DIV_W'(period_v); start_period = DIV_W'(start_v);
    ramp_dec = DIV_W'(ramp_v); old_phase = old_v;
    go = 1'b1; boundary = (b == 0);
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      n = 0;
      for (int i = 1; i <= steps_v; i++)
        if (t_step[i] <= k && t_step[i] < stop) n++;
      idx = idx0;
      for (int i = 0; i < n; i++) begin
        if (half_v || (idx % 2 == 0)) idx = dir_v ? (idx + 1) % 8 : (idx + 7) % 8;
        else                          idx = dir_v ? (idx + 2) % 8 : (idx + 6) % 8;
      end
      if (d != NEVER && k >= d + 1) idx = idx0;
      e_ph   = PTAB[idx];
      e_busy = (k < endrun);
      e_done = (k >= endrun) && (k < d);
      e_ab   = e_done && abortflag;
      n_cmp++;
      if (phase !== e_ph) begin
        n_fail++;
        $display("FAIL %s phase k=%0d got %b expected %b", name, k, phase, e_ph);
      end
      n_cmp++;
      if (busy !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy k=%0d got %b expected %b", name, k, busy, e_busy);
      end
      n_cmp++;
      if (done !== e_done) begin
        n_fail++;
        $display("FAIL %s done k=%0d got %b expected %b", name, k, done, e_done);
      end
      n_cmp++;
      if (aborted !== e_ab) begin
        n_fail++;
        $display("FAIL %s aborted k=%0d got %b expected %b", name, k, aborted, e_ab);
      end
      n_cmp++;
      if (steps_done !== STEP_W'(n)) begin
        n_fail++;
        $display("FAIL %s steps_done k=%0d got %0d expected %0d", name, k, steps_done, n);
      end
      go = (k + 1 < d);
      boundary = (k + 1 >= b);
    end
    go = 1'b0;
    boundary = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("move %s: dir=%0b half=%0b steps=%0d per=%0d start=%0d ramp=%0d old=%b bnd=%0d drop=%0d -> exp_steps=%0d exp_abort=%0b",
             name, dir_v, half_v, steps_v, period_v, start_v, ramp_v, old_v,
             (b == NEVER) ? -1 : b, (d == NEVER) ? -1 : d, n, abortflag);
  endtask

  task automatic test_reset();
    old_phase = 4'b0011;
    rst_n = 1'b0;
    #1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (phase !== 4'b1100) begin n_fail++; $display("FAIL reset_phase got %b expected 1100", phase); end
    n_cmp++;
    if ({busy, done, aborted} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b expected 000", {busy, done, aborted});
    end
    n_cmp++;
    if (steps_done !== '0) begin n_fail++; $display("FAIL reset_steps_done got %0d expected 0", steps_done); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (phase !== 4'b0011) begin n_fail++; $display("FAIL idle_follow got %b expected 0011", phase); end
    $display("reset: phase=%b busy=%b done=%b", phase, busy, done);
  endtask

  task automatic test_full_fwd();
    run_move("full_fwd", 1'b1, 1'b0, 4, 3, 3, 0, 4'b1100, NEVER, NEVER);
  endtask

  task automatic test_half_rev();
    run_move("half_rev", 1'b0, 1'b1, 3, 2, 0, 0, 4'b0110, NEVER, NEVER);
  endtask

  task automatic test_ramp();
    run_move("ramp", 1'b1, 1'b0, 5, 4, 10, 3, 4'b1100, NEVER, NEVER);
  endtask

  task automatic test_boundary();
    run_move("bnd_on_tick", 1'b1, 1'b1, 8, 3, 3, 0, 4'b1000, 9, NEVER);
    run_move("bnd_at_go", 1'b0, 1'b0, 5, 2, 2, 0, 4'b0011, 0, NEVER);
  endtask

  task automatic test_zero_steps();
    run_move("zero_steps", 1'b1, 1'b0, 0, 3, 3, 0, 4'b0110, NEVER, NEVER);
    run_move("bad_old", 1'b1, 1'b0, 2, 0, 0, 0, 4'b0000, NEVER, NEVER);
  endtask

  task automatic test_go_drop();
    run_move("go_drop", 1'b1, 1'b0, 6, 3, 3, 0, 4'b1100, NEVER, 7);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    dir = 1'b1; half_step = 1'b0; steps = STEP_W'(8); period = DIV_W'(3);
    start_period = DIV_W'(3); ramp_dec = '0; old_phase = 4'b0110; go = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (phase !== 4'b1100) begin n_fail++; $display("FAIL midrst_phase got %b expected 1100", phase); end
    n_cmp++;
    if ({busy, done, aborted} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_flags got %b expected 000", {busy, done, aborted});
    end
    n_cmp++;
    if (steps_done !== '0) begin n_fail++; $display("FAIL midrst_steps_done got %0d expected 0", steps_done); end
    go = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, phase} !== {1'b0, 4'b0110}) begin
      n_fail++; $display("FAIL midrst_release got busy=%b phase=%b expected busy=0 phase=0110", busy, phase);
    end
    $display("reset mid-run: phase=%b steps_done=%0d", phase, steps_done);
  endtask

  task automatic test_back_to_back();
    run_move("b2b_a", 1'b1, 1'b1, 3, 1, 2, 1, 4'b1001, NEVER, NEVER);
    run_move("b2b_b", 1'b0, 1'b0, 3, 1, 1, 0, 4'b1001, NEVER, NEVER);
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      int b, d;
      b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : NEVER;
      d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : NEVER;
      if (b == d) d = NEVER;
      run_move($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 12),
               $urandom_range(0, 4), 4'($urandom_range(0, 15)), b, d);
    end
  endtask

  initial begin
    test_reset();
    test_full_fwd();
    test_half_rev();
    test_ramp();
    test_boundary();
    test_zero_steps();
    test_go_drop();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
